// File: rtl/fir_decim_quant.sv
// Decimate the 17-tap FIR's full-precision sum, round/saturate to OUT_WIDTH bits,
// and buffer results in a small FIFO behind a valid/ready output handshake.
module fir_decim_quant #(
  parameter int DECIM      = 4,
  parameter int SHIFT      = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [31:0]          in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic [7:0]                  sat_cnt,
  output logic [7:0]                  drop_cnt,
  output logic                        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [32:0] MAXV = (33'sd1 <<< (OUT_WIDTH-1)) - 33'sd1;
  localparam logic signed [32:0] MINV = -(33'sd1 <<< (OUT_WIDTH-1));

  // 33-bit add keeps the half-LSB rounding term from wrapping near full scale.
  function automatic logic signed [32:0] round_shift(input logic signed [31:0] x);
    logic signed [32:0] s;
    s = $signed({x[31], x}) + (33'sd1 <<< (SHIFT-1));
    return s >>> SHIFT;
  endfunction

  function automatic logic sat_hit(input logic signed [32:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] clamp(input logic signed [32:0] v);
    if (v > MAXV) return MAXV[OUT_WIDTH-1:0];
    if (v < MINV) return MINV[OUT_WIDTH-1:0];
    return v[OUT_WIDTH-1:0];
  endfunction

  logic [3:0]                  r_phase;
  logic                        r_vld_p1;
  logic                        r_vld_p2;
  logic signed [32:0]          r_data_p1;
  logic signed [OUT_WIDTH-1:0] r_data_p2;
  logic [AW:0]                 r_wptr;
  logic [AW:0]                 r_rptr;
  logic signed [OUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [7:0]                  r_sat_cnt;
  logic [7:0]                  r_drop_cnt;
  logic                        r_overflow;

  logic w_keep;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_keep  = in_valid && (r_phase == 4'd0);
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && out_ready;
  assign w_push  = r_vld_p2 && (!w_full || w_pop);
  assign w_drop  = r_vld_p2 && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase    <= '0;
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_sat_cnt  <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (in_valid)
        r_phase <= (r_phase == 4'(DECIM-1)) ? 4'd0 : r_phase + 4'd1;
      // stage 0 -> 1: kept sample enters the rounding stage
      r_vld_p1 <= w_keep;
      // stage 1 -> 2: clamp decision, counted as stage 2 loads
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1 && sat_hit(r_data_p1) && (r_sat_cnt != 8'hFF))
        r_sat_cnt <= r_sat_cnt + 8'd1;
      // stage 2 -> FIFO
      if (w_push)
        r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)
        r_rptr <= r_rptr + (AW+1)'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF)
          r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_keep)
      r_data_p1 <= round_shift(in_data);
    if (r_vld_p1)
      r_data_p2 <= clamp(r_data_p1);
    // On full-with-pop the write lands in the slot being vacated by the head.
    if (w_push)
      r_mem[r_wptr[AW-1:0]] <= r_data_p2;
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign sat_cnt   = r_sat_cnt;
  assign drop_cnt  = r_drop_cnt;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fir_decim_quant.sv
// Bench for fir_decim_quant: a DECIM=1 and a DECIM=4 instance share the input
// stream and are compared every cycle against a queue-based reference model.
module tb_fir_decim_quant;

  localparam int SHIFT = 16;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        rdy0 = 1'b0;
  logic        rdy1 = 1'b0;

  logic        v0, v1, ov0, ov1;
  logic [15:0] d0, d1;
  logic [7:0]  s0, s1, dr0, dr1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fir_decim_quant #(.DECIM(1), .SHIFT(SHIFT), .OUT_WIDTH(16), .FIFO_DEPTH(DEPTH)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v0), .out_ready(rdy0), .out_data(d0),
    .sat_cnt(s0), .drop_cnt(dr0), .overflow(ov0)
  );

  fir_decim_quant #(.DECIM(4), .SHIFT(SHIFT), .OUT_WIDTH(16), .FIFO_DEPTH(DEPTH)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v1), .out_ready(rdy1), .out_data(d1),
    .sat_cnt(s1), .drop_cnt(dr1), .overflow(ov1)
  );

  // Reference model: output FIFO as a queue, pipeline as a list of samples
  // tagged with the edge number at which they reach the FIFO.
  typedef struct {
    int          due;
    logic [15:0] v;
    bit          s;
  } pend_t;

  logic [15:0] mq [2][$];
  pend_t       pq [2][$];
  int          cnt    [2];
  int          sat_m  [2];
  int          drop_m [2];
  bit          ovf_m  [2];
  int          e = 0;
  logic [15:0] got [$];

  function automatic logic [15:0] ref_q(input logic [31:0] x, output bit s);
    longint v, d, q;
    d = longint'(1) << SHIFT;
    v = longint'($signed(x)) + d / 2;
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    s = 1'b0;
    if (q > 32767) begin
      s = 1'b1;
      q = 32767;
    end else if (q < -32768) begin
      s = 1'b1;
      q = -32768;
    end
    return q[15:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      pq[i].delete();
      cnt[i]    = 0;
      sat_m[i]  = 0;
      drop_m[i] = 0;
      ovf_m[i]  = 1'b0;
    end
  endtask

  task automatic model_tick(input int i, input bit rdy);
    pend_t p;
    bit    s;
    int    dec;
    dec = (i == 0) ? 1 : 4;
    if (mq[i].size() > 0 && rdy) mq[i].delete(0);
    if (pq[i].size() > 0 && pq[i][0].due == e) begin
      if (mq[i].size() < DEPTH) mq[i].push_back(pq[i][0].v);
      else begin
        if (drop_m[i] < 255) drop_m[i]++;
        ovf_m[i] = 1'b1;
      end
      pq[i].delete(0);
    end
    for (int j = 0; j < pq[i].size(); j++)
      if (pq[i][j].due == e + 1 && pq[i][j].s && sat_m[i] < 255) sat_m[i]++;
    if (in_valid) begin
      if (cnt[i] % dec == 0) begin
        p.v   = ref_q(in_data, s);
        p.s   = s;
        p.due = e + 2;
        pq[i].push_back(p);
      end
      cnt[i]++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic vv, input logic [15:0] dd,
                            input logic [7:0] ss, input logic [7:0] dr, input logic ov);
    bit has;
    has = (mq[i].size() > 0);
    chk($sformatf("m%0d.valid", i), {31'b0, vv}, {31'b0, has});
    chk($sformatf("m%0d.data", i), {16'b0, dd}, {16'b0, (has ? mq[i][0] : 16'h0)});
    chk($sformatf("m%0d.sat", i), {24'b0, ss}, {24'b0, 8'(sat_m[i])});
    chk($sformatf("m%0d.drop", i), {24'b0, dr}, {24'b0, 8'(drop_m[i])});
    chk($sformatf("m%0d.ovf", i), {31'b0, ov}, {31'b0, ovf_m[i]});
  endtask

  task automatic check_all();
    check_inst(0, v0, d0, s0, dr0, ov0);
    check_inst(1, v1, d1, s1, dr1, ov1);
  endtask

  task automatic cyc(input bit v, input logic [31:0] d, input bit r0, input bit r1);
    in_valid = v;
    in_data  = d;
    rdy0     = r0;
    rdy1     = r1;
    model_tick(0, r0);
    model_tick(1, r1);
    e++;
    @(posedge clk);
    #1;
    check_all();
    if (v1 && rdy1) got.push_back(d1);
  endtask

  // Asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    model_clear();
    #2;
    chk("rst.valid", {31'b0, v0}, 32'd0);
    chk("rst.data", {16'b0, d0}, 32'd0);
    chk("rst.sat", {24'b0, s0}, 32'd0);
    chk("rst.drop", {24'b0, dr0}, 32'd0);
    chk("rst.ovf", {31'b0, ov0}, 32'd0);
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
  endtask

  initial begin
    logic [31:0] rd;
    model_clear();
    #1;
    do_reset();

    // Rounding
    cyc(1, 32'h0001_8000, 1, 1);
    cyc(1, 32'h0000_7FFF, 1, 1);
    cyc(1, 32'hFFFE_8000, 1, 1);
    chk("rnd.pos_half", {16'b0, d0}, 32'd2);
    cyc(0, 32'h0, 1, 1);
    chk("rnd.below_half.valid", {31'b0, v0}, 32'd1);
    chk("rnd.below_half", {16'b0, d0}, 32'd0);
    cyc(0, 32'h0, 1, 1);
    chk("rnd.neg_half", {16'b0, d0}, 32'h0000_FFFF);
    chk("rnd.sat", {24'b0, s0}, 32'd0);

    // Saturation
    cyc(1, 32'h7FFF_FFFF, 1, 1);
    cyc(1, 32'h8000_0000, 1, 1);
    chk("sat.cnt_at_stage2", {24'b0, s0}, 32'd1);
    cyc(0, 32'h0, 1, 1);
    chk("sat.max", {16'b0, d0}, 32'h0000_7FFF);
    cyc(0, 32'h0, 1, 1);
    chk("sat.min_exact", {16'b0, d0}, 32'h0000_8000);
    chk("sat.cnt_after_min", {24'b0, s0}, 32'd1);

    // Decimation, continuous then with gaps
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int n = 0; n < 12; n++) begin
        if (pass == 1 && $urandom_range(0, 1) == 1) cyc(0, $urandom, 1, 1);
        cyc(1, 32'(n) << 16, 1, 1);
      end
      for (int k = 0; k < 4; k++) cyc(0, 32'h0, 1, 1);
      chk($sformatf("dec%0d.count", pass), got.size(), 32'd3);
      for (int k = 0; k < 3; k++)
        chk($sformatf("dec%0d.out%0d", pass, k),
            {16'b0, (got.size() > k) ? got[k] : 16'hxxxx}, 32'(k * 4));
    end

    // Backpressure and overflow
    do_reset();
    for (int n = 1; n <= 10; n++) cyc(1, 32'(n) << 16, 0, 1);
    cyc(0, 32'h0, 0, 1);
    cyc(0, 32'h0, 0, 1);
    chk("bp.valid", {31'b0, v0}, 32'd1);
    chk("bp.drop", {24'b0, dr0}, 32'd2);
    chk("bp.ovf", {31'b0, ov0}, 32'd1);
    chk("bp.head1", {16'b0, d0}, 32'd1);
    for (int n = 2; n <= 8; n++) begin
      cyc(0, 32'h0, 1, 1);
      chk($sformatf("bp.head%0d", n), {16'b0, d0}, 32'(n));
    end
    cyc(0, 32'h0, 1, 1);
    chk("bp.empty.valid", {31'b0, v0}, 32'd0);
    chk("bp.empty.data", {16'b0, d0}, 32'd0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int n = 1; n <= 8; n++) cyc(1, 32'(n) << 16, 0, 1);
    cyc(1, 32'd100 << 16, 0, 1);
    cyc(0, 32'h0, 0, 1);
    chk("full.head", {16'b0, d0}, 32'd1);
    cyc(0, 32'h0, 1, 1);
    chk("full.pp.drop", {24'b0, dr0}, 32'd0);
    chk("full.pp.ovf", {31'b0, ov0}, 32'd0);
    chk("full.pp.head", {16'b0, d0}, 32'd2);
    for (int n = 3; n <= 8; n++) begin
      cyc(0, 32'h0, 1, 1);
      chk($sformatf("full.head%0d", n), {16'b0, d0}, 32'(n));
    end
    cyc(0, 32'h0, 1, 1);
    chk("full.tail", {16'b0, d0}, 32'd100);
    cyc(0, 32'h0, 1, 1);
    chk("full.empty", {31'b0, v0}, 32'd0);

    // Reset mid-operation: 3 queued, 2 in flight, sat_cnt nonzero
    do_reset();
    cyc(1, 32'h7FFF_FFFF, 0, 0);
    for (int n = 2; n <= 5; n++) cyc(1, 32'(n) << 16, 0, 0);
    chk("mid.sat_before", {24'b0, s0}, 32'd1);
    chk("mid.valid_before", {31'b0, v0}, 32'd1);
    do_reset();
    cyc(1, 32'd7 << 16, 1, 1);
    chk("mid.k.valid", {31'b0, v0}, 32'd0);
    cyc(0, 32'h0, 1, 1);
    chk("mid.k1.valid", {31'b0, v0}, 32'd0);
    cyc(0, 32'h0, 1, 1);
    chk("mid.k2.valid", {31'b0, v0}, 32'd1);
    chk("mid.k2.data", {16'b0, d0}, 32'd7);

    // Randomized traffic against the model, with one reset in the middle
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      case ($urandom_range(0, 3))
        0:       rd = $urandom;
        1:       rd = $urandom_range(0, 32'h0001_FFFF);
        2:       rd = -$urandom_range(0, 32'h0001_FFFF);
        default: rd = {$urandom_range(0, 32'hFFFF), 16'h8000};
      endcase
      cyc($urandom_range(0, 9) < 7, rd, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
